// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier, one multiplier bit per clock.
// Optional `MUL_OVF_EN adds the ovf flag (upper product half nonzero).
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
`ifdef MUL_OVF_EN
  ,
  output logic               ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] shifted;

  // One add per step; carry lands in the top bit of the shifted pair.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {sum, lo_q[WIDTH-1:1]};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        hi_d    = shifted[2*WIDTH-1:WIDTH];
        lo_d    = shifted[WIDTH-1:0];
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          product_d = shifted;
          state_d   = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Architectural state; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

`ifdef MUL_OVF_EN
  logic ovf_q, ovf_d;

  // Overflow flag travels with product, loaded only on completion.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && count_q == CW'(WIDTH - 1))
      ovf_d = |shifted[2*WIDTH-1:WIDTH];
  end

  // Overflow register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=32.
// Build with +define+MUL_OVF_EN to also cover the ovf flag.
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef MUL_OVF_EN
  logic           ovf;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .product(product)
`ifdef MUL_OVF_EN
    ,
    .ovf(ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  // Drive one start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    exp_q.push_back(64'(ia) * 64'(ib));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL reset_prod got %h want 0", product);
    end
`ifdef MUL_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat = 0;
    int bcnt = 1;
    logic stable = 1'b1;
    logic [2*W-1:0] prev;
    logic [2*W-1:0] e;
    int d0 = done_cnt;
    issue(32'd3, 32'd5);
    prev = product;
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = i;
        break;
      end
      if (product !== prev) stable = 1'b0;
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL basic_lat got %0d want %0d", lat, W);
    end
    e = exp_q.pop_front();
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL basic_prod got %h want %h", product, e);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL basic_run_hold product changed during RUN");
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_end busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (bcnt != W + 1 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic_busy busy_cycles=%0d dones=%0d want %0d 1",
               bcnt, done_cnt - d0, W + 1);
    end
  endtask

  task automatic test_op(input string nm, input logic [W-1:0] ia,
                         input logic [W-1:0] ib);
    int lat = 0;
    logic [2*W-1:0] e;
    issue(ia, ib);
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL %s_lat got %0d want %0d", nm, lat, W);
    end
    e = exp_q.pop_front();
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL %s_prod got %h want %h", nm, product, e);
    end
`ifdef MUL_OVF_EN
    checks++;
    if (ovf !== (e[2*W-1:W] != '0)) begin
      errors++;
      $display("FAIL %s_ovf got %b want %b", nm, ovf, e[2*W-1:W] != '0);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat = 0;
    int d0 = done_cnt;
    logic [2*W-1:0] e;
    issue(32'd7, 32'd6);
    start = 1'b1;
    a = 32'hFFFF;
    b = 32'hFFFF;
    for (int i = 1; i <= W + 5; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != W) begin
      errors++;
      $display("FAIL ign_lat got %0d want %0d", lat, W);
    end
    e = exp_q.pop_front();
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL ign_prod got %h want %h", product, e);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle busy=%b want 0", busy);
    end
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_once dones=%0d busy=%b want 1 0",
               done_cnt - d0, busy);
    end
    test_op("ign_next", 32'd11, 32'd13);
  endtask

  task automatic test_reset_mid;
    int d0;
    issue(32'd9, 32'd9);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL rstmid_async busy=%b done=%b prod=%h want 0 0 0",
               busy, done, product);
    end
    void'(exp_q.pop_back());
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL rstmid_nodone dones=%0d want 0", done_cnt - d0);
    end
    test_op("rstmid_next", 32'd2, 32'd4);
  endtask

  task automatic test_hold;
    logic ok = 1'b1;
    int d0;
    test_op("hold_op", 32'd4, 32'd7);
    d0 = done_cnt;
    repeat (50) begin
      @(negedge clk);
      if (product !== 64'h1C || done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok || done_cnt != d0) begin
      errors++;
      $display("FAIL hold prod=%h dones=%0d want 1c 0",
               product, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_const got %h want fffffffe00000001", product);
    end
    test_op("zero", 32'h1234_5678, 32'd0);
    test_op("mix", 32'h8000_0001, 32'h0000_0003);
    test_ignored_start();
    test_reset_mid();
    test_hold();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
